// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and alignment constant for the PC sequencer
package pc_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] WORD_ALIGN = 2'b00;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != WORD_ALIGN;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - priority select of the next PC with redirect alignment check
module pc_next_mux
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] branch_target,
    input  logic        branch,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    // Jump targets are word-aligned by construction; only JR and branch targets are checked.
    always_comb begin
        next_pc    = pc_plus4;
        misaligned = 1'b0;
        if (jump_reg) begin
            next_pc    = reg_target;
            misaligned = is_misaligned(reg_target);
        end else if (jump) begin
            next_pc    = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (branch) begin
            next_pc    = branch_target;
            misaligned = is_misaligned(branch_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, run/halt/fault state machine and retired-instruction counter
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      BranchTarget,
    input  logic             Branch,
    input  logic             Jump,
    input  logic [25:0]      JumpIndex,
    input  logic             JumpReg,
    input  logic [31:0]      RegTarget,
    input  logic             Stall,
    input  logic             Halt,
    output logic [31:0]      PCOut,
    output logic [31:0]      PCPlus4,
    output logic             FetchValid,
    output logic             Fault,
    output logic [31:0]      FaultPC,
    output logic [CNT_W-1:0] RetireCount
);

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      fault_pc;
    logic [CNT_W-1:0] retire_cnt;
    logic [31:0]      next_pc;
    logic             misaligned;

    assign PCPlus4 = pc + 32'd4;

    pc_next_mux u_next_mux (
        .pc_plus4      (PCPlus4),
        .branch_target (BranchTarget),
        .branch        (Branch),
        .jump          (Jump),
        .jump_index    (JumpIndex),
        .jump_reg      (JumpReg),
        .reg_target    (RegTarget),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            fault_pc   <= 32'd0;
            retire_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN: begin
                    // Halt retires itself but freezes the PC where it was decoded.
                    if (Halt) begin
                        state      <= ST_HALT;
                        retire_cnt <= retire_cnt + CNT_W'(1);
                    end else if (!Stall) begin
                        if (misaligned) begin
                            state    <= ST_FAULT;
                            fault_pc <= pc;
                        end else begin
                            pc         <= next_pc;
                            retire_cnt <= retire_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

    assign PCOut       = pc;
    assign FetchValid  = (state == ST_RUN);
    assign Fault       = (state == ST_FAULT);
    assign FaultPC     = fault_pc;
    assign RetireCount = retire_cnt;

endmodule
